// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and memory-wait states.
package hazard_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RD = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } memwait_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl: stage register ids, handshake, and stall/flush/forward controls.
interface hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int unsigned W = 32
);

  logic [REG_AW-1:0] Rs1D, Rs2D;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
  logic              ResultSrcE0;
  logic              PCSrcE;
  logic [REG_AW-1:0] RdM, RdW;
  logic              RegWriteM, RegWriteW;
  logic              MemReqM, MemAckM;

  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushW;
  logic              MemErr;
  logic [W-1:0]      StallCount, FlushCount;

  // Pipeline side: supplies register ids and handshake, consumes controls
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemAckM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr, StallCount, FlushCount
  );

  // Controller side
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemAckM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr, StallCount, FlushCount
  );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding select; the M stage wins over W, and x0 is never forwarded.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output fwd_sel_t          fwd
);

  // Priority match against the younger (M) result first
  always_comb begin
    fwd = FWD_RD;
    if (RegWriteM && (RsE != '0) && (RsE == RdM)) begin
      fwd = FWD_M;
    end else if (RegWriteW && (RsE != '0) && (RsE == RdW)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding, load-use stall, branch flush,
// and a memory-wait freeze with timeout. Define HAZARD_PERF_EN to build the
// stall/flush performance counters; otherwise those ports read 0.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  hazard_ctrl_if.slave   bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  memwait_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           memerr_q, memerr_d;
  logic           freeze_c;
  logic           lu_c;
  fwd_sel_t       fwd_a, fwd_b;

  fwd_sel u_fwd_a (
    .RsE       (bus.Rs1E),
    .RdM       (bus.RdM),
    .RdW       (bus.RdW),
    .RegWriteM (bus.RegWriteM),
    .RegWriteW (bus.RegWriteW),
    .fwd       (fwd_a)
  );

  fwd_sel u_fwd_b (
    .RsE       (bus.Rs2E),
    .RdM       (bus.RdM),
    .RdW       (bus.RdW),
    .RegWriteM (bus.RegWriteM),
    .RegWriteW (bus.RegWriteW),
    .fwd       (fwd_b)
  );

  // Memory-wait state, wait counter and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      memerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      memerr_q <= memerr_d;
    end
  end

  // Next state: the counter holds wait cycles already spent in WAIT, saturating
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    memerr_d = memerr_q;
    case (state_q)
      IDLE: begin
        if (bus.MemReqM && !bus.MemAckM) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (bus.MemAckM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
          end
          if (cnt_d >= CNT_LAST) begin
            state_d  = ERR;
            memerr_d = 1'b1;
          end
        end
      end
      ERR: begin
        memerr_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Freeze decode from the current state and handshake
  always_comb begin
    freeze_c = 1'b0;
    case (state_q)
      IDLE:    freeze_c = bus.MemReqM && !bus.MemAckM;
      WAIT:    freeze_c = !bus.MemAckM;
      default: freeze_c = 1'b0;
    endcase
  end

  // Stall/flush/forward controls; freeze overrides load-use and branch, reset forces all low
  always_comb begin
    lu_c = bus.ResultSrcE0 && (bus.RdE != '0) &&
           ((bus.Rs1D == bus.RdE) || (bus.Rs2D == bus.RdE));
    bus.ForwardAE = 2'b00;
    bus.ForwardBE = 2'b00;
    bus.StallF    = 1'b0;
    bus.StallD    = 1'b0;
    bus.StallE    = 1'b0;
    bus.StallM    = 1'b0;
    bus.FlushD    = 1'b0;
    bus.FlushE    = 1'b0;
    bus.FlushW    = 1'b0;
    if (rst_n) begin
      bus.ForwardAE = fwd_a;
      bus.ForwardBE = fwd_b;
      bus.StallF    = freeze_c || (lu_c && !bus.PCSrcE);
      bus.StallD    = freeze_c || (lu_c && !bus.PCSrcE);
      bus.StallE    = freeze_c;
      bus.StallM    = freeze_c;
      bus.FlushW    = freeze_c;
      bus.FlushD    = !freeze_c && bus.PCSrcE;
      bus.FlushE    = !freeze_c && (bus.PCSrcE || lu_c);
    end
  end

  assign bus.MemErr = memerr_q;

`ifdef HAZARD_PERF_EN
  logic [W-1:0] stall_cnt_q, stall_cnt_d;
  logic [W-1:0] flush_cnt_q, flush_cnt_d;

  // Wrapping event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.StallF) begin
      stall_cnt_d = stall_cnt_q + W'(1);
    end
    if (bus.FlushD || bus.FlushE) begin
      flush_cnt_d = flush_cnt_q + W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.StallCount = stall_cnt_q;
  assign bus.FlushCount = flush_cnt_q;
`else
  assign bus.StallCount = '0;
  assign bus.FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.W(W)) bus ();

  hazard_ctrl #(.W(W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: busy = request outstanding, waited = frozen cycles of that request
  bit           m_busy;
  int           m_waited;
  bit           m_err;
  logic [W-1:0] m_stall;
  logic [W-1:0] m_flush;

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (bus.RegWriteM && rs == bus.RdM) return 2'b10;
    if (bus.RegWriteW && rs == bus.RdW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit frz_ref();
    return rst_n && !m_err && !bus.MemAckM && (m_busy || bus.MemReqM);
  endfunction

  // {FA[1:0], FB[1:0], StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  function automatic logic [10:0] model_out();
    bit frz, lu, br;
    if (!rst_n) return 11'd0;
    frz = frz_ref();
    br  = bus.PCSrcE;
    lu  = bus.ResultSrcE0 && bus.RdE != 5'd0 &&
          (bus.Rs1D == bus.RdE || bus.Rs2D == bus.RdE);
    return {fwd_ref(bus.Rs1E), fwd_ref(bus.Rs2E),
            frz || (lu && !br), frz || (lu && !br), frz, frz,
            !frz && br, !frz && (br || lu), frz};
  endfunction

  function automatic logic [10:0] dut_out();
    return {bus.ForwardAE, bus.ForwardBE, bus.StallF, bus.StallD, bus.StallE,
            bus.StallM, bus.FlushD, bus.FlushE, bus.FlushW};
  endfunction

  task automatic cycle();
    logic [10:0] o;
    bit frz;
    @(posedge clk);
    o   = model_out();
    frz = frz_ref();
    if (!rst_n) begin
      m_busy = 0; m_waited = 0; m_err = 0; m_stall = '0; m_flush = '0;
    end else begin
`ifdef HAZARD_PERF_EN
      if (o[6]) m_stall = m_stall + 1;
      if (o[2] || o[1]) m_flush = m_flush + 1;
`endif
      if (frz) begin
        m_waited++;
        if (m_waited >= TO) begin
          m_err = 1; m_busy = 0;
        end else begin
          m_busy = 1;
        end
      end else begin
        m_busy = 0; m_waited = 0;
      end
    end
    #1;
  endtask

  task automatic zero_inputs();
    bus.Rs1D = '0; bus.Rs2D = '0; bus.Rs1E = '0; bus.Rs2E = '0; bus.RdE = '0;
    bus.ResultSrcE0 = 0; bus.PCSrcE = 0; bus.RdM = '0; bus.RdW = '0;
    bus.RegWriteM = 0; bus.RegWriteW = 0; bus.MemReqM = 0; bus.MemAckM = 0;
  endtask

  task automatic rand_inputs();
    bus.Rs1D = 5'($urandom_range(0, 7)); bus.Rs2D = 5'($urandom_range(0, 7));
    bus.Rs1E = 5'($urandom_range(0, 7)); bus.Rs2E = 5'($urandom_range(0, 7));
    bus.RdE  = 5'($urandom_range(0, 7));
    bus.RdM  = 5'($urandom_range(0, 7)); bus.RdW  = 5'($urandom_range(0, 7));
    bus.ResultSrcE0 = 1'($urandom); bus.PCSrcE = ($urandom_range(0, 3) == 0);
    bus.RegWriteM = 1'($urandom); bus.RegWriteW = 1'($urandom);
    bus.MemReqM = ($urandom_range(0, 2) == 0); bus.MemAckM = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 0;
    rand_inputs();
    bus.MemReqM = 1; bus.MemAckM = 0; bus.PCSrcE = 1;
    #1;
    total++;
    if (dut_out() !== 11'd0) begin
      bad++; $display("FAIL reset_comb: got %b want 0", dut_out());
    end
    cycle();
    cycle();
    rst_n = 1;
    zero_inputs();
    #1;
    total++;
    if (bus.MemErr !== 1'b0 || bus.StallCount !== '0 || bus.FlushCount !== '0) begin
      bad++; $display("FAIL reset_regs: err=%b sc=%0d fc=%0d want 0/0/0",
                      bus.MemErr, bus.StallCount, bus.FlushCount);
    end
    total++;
    if (dut_out() !== 11'd0) begin
      bad++; $display("FAIL reset_idle: got %b want 0", dut_out());
    end
  endtask

  task automatic test_forward();
    zero_inputs();
    bus.Rs1E = 5'd5; bus.RdM = 5'd5; bus.RegWriteM = 1; bus.RdW = 5'd5; bus.RegWriteW = 1;
    #1;
    total++;
    if (bus.ForwardAE !== 2'b10) begin
      bad++; $display("FAIL fwd_m_prio: got %b want 10", bus.ForwardAE);
    end
    bus.Rs1E = 5'd0;
    #1;
    total++;
    if (bus.ForwardAE !== 2'b00) begin
      bad++; $display("FAIL fwd_x0: got %b want 00", bus.ForwardAE);
    end
    bus.Rs1E = 5'd5; bus.RegWriteM = 0;
    #1;
    total++;
    if (bus.ForwardAE !== 2'b01) begin
      bad++; $display("FAIL fwd_w: got %b want 01", bus.ForwardAE);
    end
    for (int i = 0; i < 40; i++) begin
      rand_inputs();
      bus.MemReqM = 0;
      #1;
      total++;
      if ({bus.ForwardAE, bus.ForwardBE} !== {fwd_ref(bus.Rs1E), fwd_ref(bus.Rs2E)}) begin
        bad++; $display("FAIL fwd_rand: got %b%b want %b%b", bus.ForwardAE, bus.ForwardBE,
                        fwd_ref(bus.Rs1E), fwd_ref(bus.Rs2E));
      end
    end
    zero_inputs();
    cycle();
  endtask

  task automatic test_load_use();
    zero_inputs();
    bus.ResultSrcE0 = 1; bus.RdE = 5'd7; bus.Rs2D = 5'd7;
    #1;
    total++;
    if ({bus.StallF, bus.StallD, bus.FlushD, bus.FlushE, bus.StallE} !== 5'b11010) begin
      bad++; $display("FAIL lu_stall: got %b want 11010",
                      {bus.StallF, bus.StallD, bus.FlushD, bus.FlushE, bus.StallE});
    end
    bus.PCSrcE = 1;
    #1;
    total++;
    if ({bus.StallF, bus.StallD, bus.FlushD, bus.FlushE} !== 4'b0011) begin
      bad++; $display("FAIL lu_branch: got %b want 0011",
                      {bus.StallF, bus.StallD, bus.FlushD, bus.FlushE});
    end
    cycle();
    zero_inputs();
    bus.ResultSrcE0 = 1; bus.RdE = 5'd0; bus.Rs1D = 5'd0;
    #1;
    total++;
    if ({bus.StallF, bus.FlushE} !== 2'b00) begin
      bad++; $display("FAIL lu_x0: got %b want 00", {bus.StallF, bus.FlushE});
    end
    zero_inputs();
    #1;
    total++;
    if (dut_out() !== 11'd0) begin
      bad++; $display("FAIL lu_release: got %b want 0", dut_out());
    end
    cycle();
  endtask

  task automatic test_mem_wait();
    zero_inputs();
    bus.MemReqM = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushW} !== 5'b11111) begin
        bad++; $display("FAIL wait_freeze%0d: got %b want 11111", i,
                        {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushW});
      end
      cycle();
    end
    bus.MemAckM = 1;
    #1;
    total++;
    if (bus.StallE !== 1'b0 || bus.FlushW !== 1'b0) begin
      bad++; $display("FAIL wait_ack: stallE=%b flushW=%b want 0/0", bus.StallE, bus.FlushW);
    end
    cycle();
    zero_inputs();
    #1;
    total++;
    if (bus.StallE !== 1'b0 || bus.MemErr !== 1'b0) begin
      bad++; $display("FAIL wait_idle: stallE=%b err=%b want 0/0", bus.StallE, bus.MemErr);
    end
    bus.MemReqM = 1;
    cycle();
    bus.MemReqM = 0;
    #1;
    total++;
    if (bus.StallM !== 1'b1) begin
      bad++; $display("FAIL wait_req_drop: stallM=%b want 1", bus.StallM);
    end
    cycle();
    bus.MemAckM = 1;
    cycle();
    zero_inputs();
    cycle();
  endtask

  task automatic test_timeout();
    zero_inputs();
    bus.MemReqM = 1;
    for (int i = 0; i < int'(TO); i++) begin
      #1;
      total++;
      if (bus.StallE !== 1'b1) begin
        bad++; $display("FAIL to_freeze%0d: got %b want 1", i, bus.StallE);
      end
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.StallE !== 1'b0 || bus.MemErr !== 1'b1) begin
        bad++; $display("FAIL to_err%0d: stallE=%b err=%b want 0/1", i, bus.StallE, bus.MemErr);
      end
      cycle();
    end
    rst_n = 0;
    cycle();
    rst_n = 1;
    zero_inputs();
    #1;
    total++;
    if (bus.MemErr !== 1'b0) begin
      bad++; $display("FAIL to_reset: err=%b want 0", bus.MemErr);
    end
  endtask

  task automatic test_freeze_branch();
    zero_inputs();
    rst_n = 0;
    cycle();
    rst_n = 1;
    bus.MemReqM = 1; bus.PCSrcE = 1;
    bus.ResultSrcE0 = 1; bus.RdE = 5'd3; bus.Rs1D = 5'd3;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if ({bus.StallF, bus.FlushD, bus.FlushE} !== 3'b100) begin
        bad++; $display("FAIL frz_br%0d: got %b want 100", i, {bus.StallF, bus.FlushD, bus.FlushE});
      end
      cycle();
    end
    bus.MemAckM = 1;
    #1;
    total++;
    if ({bus.StallF, bus.FlushD, bus.FlushE} !== 3'b011) begin
      bad++; $display("FAIL frz_replay: got %b want 011", {bus.StallF, bus.FlushD, bus.FlushE});
    end
    cycle();
    bus.PCSrcE = 0; bus.MemReqM = 0; bus.MemAckM = 0;
    cycle();
    zero_inputs();
    #1;
    total++;
`ifdef HAZARD_PERF_EN
    if (bus.StallCount !== W'(3) || bus.FlushCount !== W'(2)) begin
      bad++; $display("FAIL perf_cnt: sc=%0d fc=%0d want 3/2", bus.StallCount, bus.FlushCount);
    end
`else
    if (bus.StallCount !== '0 || bus.FlushCount !== '0) begin
      bad++; $display("FAIL perf_tied: sc=%0d fc=%0d want 0/0", bus.StallCount, bus.FlushCount);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      rst_n = ($urandom_range(0, 29) != 0);
      #1;
      total++;
      if (dut_out() !== model_out()) begin
        bad++; $display("FAIL rand_ctl[%0d]: got %b want %b", i, dut_out(), model_out());
      end
      total++;
      if (bus.MemErr !== m_err || bus.StallCount !== m_stall || bus.FlushCount !== m_flush) begin
        bad++; $display("FAIL rand_regs[%0d]: err=%b sc=%0d fc=%0d want %b/%0d/%0d", i,
                        bus.MemErr, bus.StallCount, bus.FlushCount, m_err, m_stall, m_flush);
      end
      cycle();
    end
    rst_n = 1;
  endtask

  initial begin
    m_busy = 0; m_waited = 0; m_err = 0; m_stall = '0; m_flush = '0;
    zero_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_freeze_branch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
